// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the pipeline stall/flush
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        DMEM_WAIT = 2'b01,
        DROP      = 2'b10
    } pipe_state_t;

    // Bubble instruction (addi x0,x0,0) loaded by a flush; all write enables 0.
    localparam logic [31:0] c_nop_instr = 32'h0000_0013;

    localparam int c_cnt_w_default = 16;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && !(&r_q)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Stall/flush controller for the 5-stage core; per-stage enables,
//               flush strobes, BubbleMA flag and stall/flush statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W     = c_cnt_w_default,
    parameter int MAX_STALL = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Need_Stall,
    input  logic             EX__Branch_Taken,
    input  logic             IMEM__Busy,
    input  logic             DMEM__Busy,
    input  logic             Cnt_Clr,
    output logic             PC_En,
    output logic             IFid_En,
    output logic             IDex_En,
    output logic             EXmem_En,
    output logic             MEMwb_En,
    output logic             IFid_Flush,
    output logic             IDex_Flush,
    output logic             EXmem_Flush,
    output logic             MEMwb_Flush,
    output logic             BubbleMA,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt,
    output logic             Stall_Timeout
);

    localparam logic [CNT_W-1:0] c_max_stall = CNT_W'(MAX_STALL);

    pipe_state_t      r_state;
    pipe_state_t      w_state_nxt;
    pipe_state_t      w_eff;
    logic             r_drop_pend;
    logic             w_drop_pend_nxt;
    logic             r_bubble;
    logic             w_bubble_nxt;
    logic             w_redirect;
    logic [CNT_W-1:0] r_run;
    logic [CNT_W-1:0] w_run_nxt;
    logic             r_timeout;

    logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
    logic w_ifid_fl, w_idex_fl, w_exmem_fl, w_memwb_fl;

    // Once memory releases, DMEM_WAIT behaves as the state it was entered from.
    always_comb begin
        w_eff           = (r_state == DMEM_WAIT) ? (r_drop_pend ? DROP : RUN) : r_state;
        w_state_nxt     = w_eff;
        w_drop_pend_nxt = r_drop_pend;
        w_bubble_nxt    = 1'b0;
        w_redirect      = 1'b0;
        w_pc_en         = 1'b1;
        w_ifid_en       = 1'b1;
        w_idex_en       = 1'b1;
        w_exmem_en      = 1'b1;
        w_memwb_en      = 1'b1;
        w_ifid_fl       = 1'b0;
        w_idex_fl       = 1'b0;
        w_exmem_fl      = 1'b0;
        w_memwb_fl      = 1'b0;

        if (DMEM__Busy) begin
            w_pc_en         = 1'b0;
            w_ifid_en       = 1'b0;
            w_idex_en       = 1'b0;
            w_exmem_en      = 1'b0;
            w_memwb_fl      = 1'b1;
            w_state_nxt     = DMEM_WAIT;
            w_drop_pend_nxt = (w_eff == DROP);
        end else if (EX__Branch_Taken) begin
            w_ifid_fl   = 1'b1;
            w_idex_fl   = 1'b1;
            w_redirect  = 1'b1;
            w_state_nxt = (IMEM__Busy || (w_eff == DROP)) ? DROP : RUN;
        end else if (Need_Stall) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_fl    = 1'b1;
            w_bubble_nxt = 1'b1;
            w_state_nxt  = ((w_eff == DROP) && IMEM__Busy) ? DROP : RUN;
        end else if (IMEM__Busy) begin
            w_pc_en   = 1'b0;
            w_ifid_fl = 1'b1;
        end else if (w_eff == DROP) begin
            // Wrong-path fetch has just landed: discard it.
            w_ifid_fl   = 1'b1;
            w_state_nxt = RUN;
        end

        if (!rst) begin
            w_pc_en    = 1'b0;
            w_ifid_en  = 1'b0;
            w_idex_en  = 1'b0;
            w_exmem_en = 1'b0;
            w_memwb_en = 1'b0;
            w_ifid_fl  = 1'b1;
            w_idex_fl  = 1'b1;
            w_exmem_fl = 1'b1;
            w_memwb_fl = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_drop_pend <= 1'b0;
            r_bubble    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drop_pend <= w_drop_pend_nxt;
            r_bubble    <= w_bubble_nxt;
        end
    end

    always_comb begin
        w_run_nxt = r_run;
        if (Cnt_Clr || w_pc_en) begin
            w_run_nxt = '0;
        end else if (r_run != c_max_stall) begin
            w_run_nxt = r_run + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_run     <= w_run_nxt;
            r_timeout <= !Cnt_Clr && (r_timeout || (w_run_nxt == c_max_stall));
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (!w_pc_en),
        .clr (Cnt_Clr),
        .q   (Stall_Cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_redirect),
        .clr (Cnt_Clr),
        .q   (Flush_Cnt)
    );

    assign PC_En         = w_pc_en;
    assign IFid_En       = w_ifid_en;
    assign IDex_En       = w_idex_en;
    assign EXmem_En      = w_exmem_en;
    assign MEMwb_En      = w_memwb_en;
    assign IFid_Flush    = w_ifid_fl;
    assign IDex_Flush    = w_idex_fl;
    assign EXmem_Flush   = w_exmem_fl;
    assign MEMwb_Flush   = w_memwb_fl;
    assign BubbleMA      = r_bubble;
    assign Stall_Timeout = r_timeout;

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed self-checking bench for pipe_ctrl (MAX_STALL = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int CNT_W = 16;

    // Strobe vector order: PC, IFid, IDex, EXmem, MEMwb enables, then the four flushes.
    localparam logic [8:0] c_RST  = 9'b0_0000_1111;
    localparam logic [8:0] c_IDLE = 9'b1_1111_0000;
    localparam logic [8:0] c_LU   = 9'b0_0111_0100;
    localparam logic [8:0] c_BR   = 9'b1_1111_1100;
    localparam logic [8:0] c_DM   = 9'b0_0001_0001;
    localparam logic [8:0] c_IM   = 9'b0_1111_1000;
    localparam logic [8:0] c_DROP = 9'b1_1111_1000;

    logic clk = 1'b0;
    logic rst;
    logic Need_Stall, EX__Branch_Taken, IMEM__Busy, DMEM__Busy, Cnt_Clr;
    logic PC_En, IFid_En, IDex_En, EXmem_En, MEMwb_En;
    logic IFid_Flush, IDex_Flush, EXmem_Flush, MEMwb_Flush;
    logic BubbleMA, Stall_Timeout;
    logic [CNT_W-1:0] Stall_Cnt, Flush_Cnt;
    logic [8:0] w_strb;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .CNT_W     (CNT_W),
        .MAX_STALL (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .Need_Stall       (Need_Stall),
        .EX__Branch_Taken (EX__Branch_Taken),
        .IMEM__Busy       (IMEM__Busy),
        .DMEM__Busy       (DMEM__Busy),
        .Cnt_Clr          (Cnt_Clr),
        .PC_En            (PC_En),
        .IFid_En          (IFid_En),
        .IDex_En          (IDex_En),
        .EXmem_En         (EXmem_En),
        .MEMwb_En         (MEMwb_En),
        .IFid_Flush       (IFid_Flush),
        .IDex_Flush       (IDex_Flush),
        .EXmem_Flush      (EXmem_Flush),
        .MEMwb_Flush      (MEMwb_Flush),
        .BubbleMA         (BubbleMA),
        .Stall_Cnt        (Stall_Cnt),
        .Flush_Cnt        (Flush_Cnt),
        .Stall_Timeout    (Stall_Timeout)
    );

    assign w_strb = {PC_En, IFid_En, IDex_En, EXmem_En, MEMwb_En,
                     IFid_Flush, IDex_Flush, EXmem_Flush, MEMwb_Flush};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ns, input logic br, input logic ib,
                         input logic db, input logic cc);
        Need_Stall       = ns;
        EX__Branch_Taken = br;
        IMEM__Busy       = ib;
        DMEM__Busy       = db;
        Cnt_Clr          = cc;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt;
        drive(0, 0, 0, 0, 1);
        tick;
        drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        #2;
        check_eq("rst_strb",    32'(w_strb), 32'(c_RST));
        check_eq("rst_stall",   32'(Stall_Cnt), 0);
        check_eq("rst_bubble",  32'(BubbleMA), 0);
        #10;
        rst = 1'b1;
        #1;
        check_eq("idle_strb",   32'(w_strb), 32'(c_IDLE));
        tick;

        // Load-use stall in RUN
        drive(1, 0, 0, 0, 0);
        #1;
        check_eq("lu_strb",     32'(w_strb), 32'(c_LU));
        tick;
        drive(0, 0, 0, 0, 0);
        #1;
        check_eq("lu_bubble",   32'(BubbleMA), 1);
        check_eq("lu_stall",    32'(Stall_Cnt), 1);
        check_eq("lu_after",    32'(w_strb), 32'(c_IDLE));
        tick;
        check_eq("lu_bub_clr",  32'(BubbleMA), 0);

        // Branch beats load-use
        clr_cnt;
        drive(1, 1, 0, 0, 0);
        #1;
        check_eq("brlu_strb",   32'(w_strb), 32'(c_BR));
        tick;
        drive(0, 0, 0, 0, 0);
        #1;
        check_eq("brlu_bubble", 32'(BubbleMA), 0);
        check_eq("brlu_flush",  32'(Flush_Cnt), 1);
        check_eq("brlu_stall",  32'(Stall_Cnt), 0);

        // DMEM busy freezes a pending branch
        clr_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 1, 0);
            #1;
            check_eq($sformatf("dm_strb%0d", i), 32'(w_strb), 32'(c_DM));
            tick;
        end
        check_eq("dm_stall",    32'(Stall_Cnt), 3);
        check_eq("dm_flush0",   32'(Flush_Cnt), 0);
        drive(0, 1, 0, 0, 0);
        #1;
        check_eq("dm_br_strb",  32'(w_strb), 32'(c_BR));
        tick;
        drive(0, 0, 0, 0, 0);
        #1;
        check_eq("dm_flush1",   32'(Flush_Cnt), 1);
        check_eq("dm_to",       32'(Stall_Timeout), 0);
        tick;

        // Branch during busy fetch -> DROP
        clr_cnt;
        drive(0, 1, 1, 0, 0);
        #1;
        check_eq("drop_br",     32'(w_strb), 32'(c_BR));
        tick;
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 0, 0);
            #1;
            check_eq($sformatf("drop_im%0d", i), 32'(w_strb), 32'(c_IM));
            tick;
        end
        drive(0, 0, 0, 0, 0);
        #1;
        check_eq("drop_discard", 32'(w_strb), 32'(c_DROP));
        tick;
        check_eq("drop_run",    32'(w_strb), 32'(c_IDLE));
        check_eq("drop_flush",  32'(Flush_Cnt), 1);
        check_eq("drop_stall",  32'(Stall_Cnt), 2);
        tick;

        // Stall timeout at MAX_STALL = 4
        clr_cnt;
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 0, 1, 0);
            tick;
            if (i == 3) check_eq("to_before", 32'(Stall_Timeout), 0);
            if (i == 4) check_eq("to_set",    32'(Stall_Timeout), 1);
        end
        drive(0, 0, 0, 0, 0);
        tick;
        check_eq("to_sticky",   32'(Stall_Timeout), 1);
        check_eq("to_stall",    32'(Stall_Cnt), 5);
        clr_cnt;
        check_eq("to_clr",      32'(Stall_Timeout), 0);
        check_eq("to_clr_cnt",  32'(Stall_Cnt), 0);
        drive(1, 0, 0, 0, 1);
        tick;
        drive(0, 0, 0, 0, 0);
        check_eq("clr_prio",    32'(Stall_Cnt), 0);
        tick;

        // Asynchronous reset in DMEM_WAIT with a DROP pending
        clr_cnt;
        drive(0, 1, 1, 0, 0);
        tick;
        drive(0, 0, 0, 1, 0);
        tick;
        tick;
        check_eq("pre_rst_stall", 32'(Stall_Cnt), 2);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_strb",   32'(w_strb), 32'(c_RST));
        check_eq("arst_stall",  32'(Stall_Cnt), 0);
        check_eq("arst_flush",  32'(Flush_Cnt), 0);
        check_eq("arst_bubble", 32'(BubbleMA), 0);
        drive(0, 0, 0, 0, 0);
        tick;
        #2;
        rst = 1'b1;
        #1;
        check_eq("rel_strb",    32'(w_strb), 32'(c_IDLE));
        tick;
        check_eq("rel_run",     32'(w_strb), 32'(c_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pipe_ctrl
`default_nettype wire
